// File: rtl/dmrs_pingpong_buf.sv
// rtl/dmrs_pingpong_buf.sv - two-bank DMRS symbol store with writer/reader bank handover
module dmrs_pingpong_buf #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 600,
  parameter int AW    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           cfg_num_sc,
  input  logic                    DMRS_valid,
  input  logic signed [WIDTH-1:0] DMRS_r_in,
  input  logic signed [WIDTH-1:0] DMRS_i_in,
  output logic                    wr_ready,
  output logic                    sym_ready,
  output logic [AW-1:0]           rd_len,
  input  logic                    rd_en,
  input  logic [AW-1:0]           read_ptr,
  input  logic                    rd_release,
  output logic signed [WIDTH-1:0] DMRS_r_out,
  output logic signed [WIDTH-1:0] DMRS_i_out,
  output logic                    rd_valid,
  output logic                    ovf_err,
  output logic                    short_err
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_BLOCKED} w_state_e;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_e;

  localparam logic [AW-1:0] DEPTH_W    = AW'(DEPTH);
  localparam logic [AW:0]   BANK1_BASE = (AW+1)'(DEPTH);

  w_state_e               w_state_q, w_state_d;
  bank_state_e            bank_q [2];
  bank_state_e            bank_d [2];
  logic [AW-1:0]          len_q [2];
  logic [AW-1:0]          len_d [2];
  logic                   wr_bank_q, wr_bank_d;
  logic [AW-1:0]          count_q, count_d;
  logic                   rd_own_q, rd_own_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [AW-1:0]          rd_len_q, rd_len_d;
  logic signed [WIDTH-1:0] r_out_q, i_out_q;
  logic                   rd_valid_q, ovf_q, short_q;
  logic [2*WIDTH-1:0]     mem [2*DEPTH];

  logic          other_bank, other_free;
  logic [AW-1:0] cfg_len, cur_len, wr_addr;
  logic          w_start, w_write, w_done, w_abort, w_drop;
  logic          full0, full1, rd_take, take_bank, rd_rel, rd_hit;
  logic [AW:0]   wr_maddr, rd_maddr;

  assign other_bank = ~wr_bank_q;
  assign cfg_len    = (cfg_num_sc == '0 || cfg_num_sc > DEPTH_W) ? DEPTH_W : cfg_num_sc;

  assign full0     = (bank_q[0] == B_FULL);
  assign full1     = (bank_q[1] == B_FULL);
  assign rd_take   = !rd_own_q && (full0 || full1);
  // With both banks full the writer is parked on the older one, so that is the one to hand over.
  assign take_bank = (full0 && full1) ? wr_bank_q : full1;
  assign rd_rel    = rd_release && rd_own_q;
  assign rd_hit    = rd_own_q && (read_ptr < rd_len_q);

  // A bank being released this cycle counts as free so a back-to-back symbol is not dropped.
  assign other_free = (bank_q[other_bank] == B_EMPTY) || (rd_rel && rd_bank_q == other_bank);

  assign wr_maddr = (wr_bank_q ? BANK1_BASE : '0) + {1'b0, wr_addr};
  assign rd_maddr = (rd_bank_q ? BANK1_BASE : '0) + {1'b0, read_ptr};

  // Writer FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Writer FSM: next state
  always_comb begin
    w_state_d = w_state_q;
    if (w_done)       w_state_d = other_free ? W_IDLE : W_BLOCKED;
    else if (w_start) w_state_d = W_FILL;
    else if (w_abort) w_state_d = W_IDLE;
    else if (w_state_q == W_BLOCKED && bank_q[wr_bank_q] == B_EMPTY) w_state_d = W_IDLE;
  end

  // Writer FSM: outputs
  always_comb begin
    wr_ready = 1'b0;
    w_start  = 1'b0;
    w_write  = 1'b0;
    w_abort  = 1'b0;
    w_drop   = 1'b0;
    wr_addr  = count_q;
    cur_len  = len_q[wr_bank_q];
    unique case (w_state_q)
      W_IDLE: begin
        wr_ready = (bank_q[wr_bank_q] == B_EMPTY);
        wr_addr  = '0;
        cur_len  = cfg_len;
        if (DMRS_valid) begin
          if (wr_ready) begin
            w_start = 1'b1;
            w_write = 1'b1;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      W_FILL: begin
        wr_ready = 1'b1;
        if (DMRS_valid) w_write = 1'b1;
        else            w_abort = 1'b1;
      end
      default: w_drop = DMRS_valid;
    endcase
    w_done = w_write && (wr_addr == cur_len - 1'b1);
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    count_d   = count_q;
    rd_own_d  = rd_own_q;
    rd_bank_d = rd_bank_q;
    rd_len_d  = rd_len_q;
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      len_d[b]  = len_q[b];
    end
    if (w_start) begin
      len_d[wr_bank_q]  = cfg_len;
      bank_d[wr_bank_q] = B_FILLING;
    end
    if (w_write) count_d = wr_addr + 1'b1;
    if (w_done) begin
      bank_d[wr_bank_q] = B_FULL;
      wr_bank_d         = other_bank;
      count_d           = '0;
    end
    if (w_abort) begin
      bank_d[wr_bank_q] = B_EMPTY;
      count_d           = '0;
    end
    if (rd_rel) begin
      bank_d[rd_bank_q] = B_EMPTY;
      rd_own_d          = 1'b0;
      rd_len_d          = '0;
    end
    if (rd_take) begin
      bank_d[take_bank] = B_READING;
      rd_own_d          = 1'b1;
      rd_bank_d         = take_bank;
      rd_len_d          = len_q[take_bank];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q  <= 1'b0;
      count_q    <= '0;
      rd_own_q   <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_len_q   <= '0;
      r_out_q    <= '0;
      i_out_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= B_EMPTY;
        len_q[b]  <= '0;
      end
    end else begin
      wr_bank_q  <= wr_bank_d;
      count_q    <= count_d;
      rd_own_q   <= rd_own_d;
      rd_bank_q  <= rd_bank_d;
      rd_len_q   <= rd_len_d;
      rd_valid_q <= rd_en;
      ovf_q      <= w_drop;
      short_q    <= w_abort;
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= bank_d[b];
        len_q[b]  <= len_d[b];
      end
      // Reads outside the owned symbol return zero rather than stale or unwritten RAM.
      if (rd_en) begin
        if (rd_hit) begin
          {r_out_q, i_out_q} <= mem[rd_maddr];
        end else begin
          r_out_q <= '0;
          i_out_q <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) mem[wr_maddr] <= {DMRS_r_in, DMRS_i_in};
  end

  assign sym_ready  = rd_own_q;
  assign rd_len     = rd_len_q;
  assign DMRS_r_out = r_out_q;
  assign DMRS_i_out = i_out_q;
  assign rd_valid   = rd_valid_q;
  assign ovf_err    = ovf_q;
  assign short_err  = short_q;

endmodule
